// File: rtl/cc_loader_pkg.sv
// Shared types and constants for the ROM download loader: sequencer states,
// write-engine phases and the image slice to chip region table.
package cc_loader_pkg;

  localparam int unsigned SLICE_BYTES = 8192;
  localparam int unsigned IMG_BYTES   = 5 * SLICE_BYTES;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE,
    ERROR
  } state_t;

  typedef enum logic [1:0] {
    ENG_IDLE,
    ENG_WR,
    ENG_HOLD
  } eng_t;

  // Slices 0..4 of the image land in chips 1F, 1H, 1K, 1L, 1N.
  function automatic logic [2:0] slice_region(input logic [2:0] slice);
    logic [2:0] region;
    region = 3'd0;
    case (slice)
      3'd0:    region = 3'd0;
      3'd1:    region = 3'd1;
      3'd2:    region = 3'd4;
      3'd3:    region = 3'd5;
      3'd4:    region = 3'd6;
      default: region = 3'd0;
    endcase
    return region;
  endfunction

endpackage

// File: rtl/rom_loader_ctrl_if.sv
// Download stream in, program-memory write port out. The master is the
// ROM stream source; the slave is the loader.
interface rom_loader_ctrl_if;

  // ioctl_wr is a one-cycle byte strobe with no ready path of its own; the
  // source must stop strobing while ioctl_wait is high, tolerating at most one
  // strobe of sample-to-stall delay. dn_wr is a one-cycle write with no backpressure.
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [15:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        dn_wr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait, dn_wr, dn_addr, dn_data
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait, dn_wr, dn_addr, dn_data
  );

endinterface

// File: rtl/rom_loader_ctrl.sv
// Remaps the 40 KiB ROM download stream onto the program memory write port,
// with a one-byte skid register, running count/checksum and CPU hold control.
module rom_loader_ctrl
  import cc_loader_pkg::*;
#(
  parameter int unsigned IMG_BYTES = cc_loader_pkg::IMG_BYTES,
  parameter logic [7:0]  ROM_INDEX = 8'd0
) (
  input  logic             clk,
  input  logic             reset,
  rom_loader_ctrl_if.slave bus,
  output logic             cpu_hold,
  output logic             rom_ready,
  output logic             load_error,
  output logic [7:0]       checksum,
  output state_t           dbg_state
);

  state_t      state;
  eng_t        eng;
  logic        act_q;
  logic        skid_full;
  logic [15:0] skid_addr;
  logic [7:0]  skid_data;
  logic [16:0] byte_cnt;
  logic        overrun;
  logic        oversize;

  logic        idx_match, active, rise, strobe, in_range, take, oob, drop;
  logic        launch_skid, launch_direct, launch, capture, drained;
  logic [15:0] src_addr;
  logic [7:0]  src_data;

  always_comb begin
    idx_match     = (bus.ioctl_index == ROM_INDEX);
    active        = bus.ioctl_download && idx_match;
    rise          = active && !act_q;
    // act_q keeps a strobe that coincides with the window closing.
    strobe        = bus.ioctl_wr && idx_match && (bus.ioctl_download || act_q);
    in_range      = 32'(bus.ioctl_addr) < IMG_BYTES;
    take          = strobe && in_range;
    oob           = strobe && !in_range;
    drop          = take && skid_full;
    launch_skid   = skid_full && (eng != ENG_WR);
    launch_direct = take && !skid_full && (eng == ENG_IDLE);
    launch        = launch_skid || launch_direct;
    capture       = take && !skid_full && (eng != ENG_IDLE);
    drained       = (eng != ENG_WR) && !skid_full && !take;
    src_addr      = skid_full ? skid_addr : bus.ioctl_addr;
    src_data      = skid_full ? skid_data : bus.ioctl_dout;
  end

  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      eng            <= ENG_IDLE;
      act_q          <= 1'b0;
      skid_full      <= 1'b0;
      skid_addr      <= 16'd0;
      skid_data      <= 8'd0;
      byte_cnt       <= 17'd0;
      overrun        <= 1'b0;
      oversize       <= 1'b0;
      bus.dn_wr      <= 1'b0;
      bus.dn_addr    <= 16'd0;
      bus.dn_data    <= 8'd0;
      bus.ioctl_wait <= 1'b0;
      checksum       <= 8'd0;
      cpu_hold       <= 1'b1;
      rom_ready      <= 1'b0;
      load_error     <= 1'b0;
    end else begin
      act_q <= active;

      case (eng)
        ENG_WR:  eng <= ENG_HOLD;
        default: eng <= launch ? ENG_WR : ENG_IDLE;
      endcase

      bus.dn_wr <= launch;
      if (launch) begin
        bus.dn_addr <= {slice_region(src_addr[15:13]), src_addr[12:0]};
        bus.dn_data <= src_data;
      end

      if (capture) begin
        skid_full <= 1'b1;
        skid_addr <= bus.ioctl_addr;
        skid_data <= bus.ioctl_dout;
      end else if (launch_skid) begin
        skid_full <= 1'b0;
      end
      // Stays up for the cycle in which the skid drains.
      bus.ioctl_wait <= skid_full || capture;

      byte_cnt <= (rise ? 17'd0 : byte_cnt) + {16'd0, launch};
      checksum <= (rise ? 8'd0 : checksum) + (launch ? src_data : 8'd0);
      overrun  <= (overrun && !rise) || drop;
      oversize <= (oversize && !rise) || oob;

      if (rise) begin
        state      <= LOAD;
        cpu_hold   <= 1'b1;
        rom_ready  <= 1'b0;
        load_error <= 1'b0;
      end else begin
        case (state)
          LOAD: if (!bus.ioctl_download) state <= FLUSH;
          FLUSH: begin
            if (drained) begin
              if (byte_cnt == 17'(IMG_BYTES) && !overrun && !oversize) begin
                state     <= DONE;
                cpu_hold  <= 1'b0;
                rom_ready <= 1'b1;
              end else begin
                state      <= ERROR;
                load_error <= 1'b1;
              end
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule
